// File: rtl/interval_timer_pkg.sv
// Register map, CTRL field positions and shared types for the 6502-bus interval timer.
package interval_timer_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned PRE_W   = 8;
    localparam int unsigned PSEL_W  = 2;

    localparam logic [ADDR_W-1:0] REG_LATCH_LO = 2'd0;
    localparam logic [ADDR_W-1:0] REG_LATCH_HI = 2'd1;
    localparam logic [ADDR_W-1:0] REG_CTRL     = 2'd2;
    localparam logic [ADDR_W-1:0] REG_STATUS   = 2'd3;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_CONT_BIT = 1;
    localparam int unsigned CTRL_IE_BIT   = 2;
    localparam int unsigned CTRL_PSEL_LSB = 3;
    localparam int unsigned STATUS_FLAG_BIT = 0;

    typedef struct packed {
        logic [PSEL_W-1:0] psel;
        logic              ie;
        logic              cont;
        logic              en;
    } ctrl_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_t;

    // Terminal prescaler value (divide ratio minus one) for each psel code.
    function automatic logic [PRE_W-1:0] psel_to_div(input logic [PSEL_W-1:0] psel);
        case (psel)
            2'd0:    return PRE_W'(0);
            2'd1:    return PRE_W'(7);
            2'd2:    return PRE_W'(63);
            default: return PRE_W'(255);
        endcase
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: emits one tick every (terminal+1) clocks while enabled.
module timer_prescaler
    import interval_timer_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [PRE_W-1:0] i_term,
    output logic             o_tick
);

    logic [PRE_W-1:0] pre_q;

    assign o_tick = i_en & (pre_q == i_term);

    // Held at zero while disabled so every enable starts a full prescale period.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pre_q <= '0;
        end else if (!i_en || i_clear || o_tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

endmodule

// File: rtl/interval_timer.sv
// 16-bit down-counting interval timer with one-shot/auto-reload modes, a byte-wide
// register interface committed on the rising edge of phi2, and an active-low IRQ.
module interval_timer
    import interval_timer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_phi2,
    input  logic              i_cs,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rw,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_irq_n
);

    logic               phi2_q;
    logic [COUNT_W-1:0] latch_q;
    logic [COUNT_W-1:0] count_q;
    logic [DATA_W-1:0]  hi_snap_q;
    ctrl_t              ctrl_q;
    logic               flag_q;
    timer_state_t       state_q;

    logic  acc;
    logic  wr;
    logic  rd;
    logic  ctrl_wr;
    logic  hi_wr;
    logic  tick;
    logic  cnt_evt;
    logic  underflow;
    ctrl_t ctrl_wdata;

    assign acc     = i_cs & i_phi2 & ~phi2_q;
    assign wr      = acc & ~i_rw;
    assign rd      = acc & i_rw;
    assign ctrl_wr = wr & (i_addr == REG_CTRL);
    assign hi_wr   = wr & (i_addr == REG_LATCH_HI);

    always_comb begin
        ctrl_wdata      = '0;
        ctrl_wdata.en   = i_data[CTRL_EN_BIT];
        ctrl_wdata.cont = i_data[CTRL_CONT_BIT];
        ctrl_wdata.ie   = i_data[CTRL_IE_BIT];
        ctrl_wdata.psel = i_data[CTRL_PSEL_LSB +: PSEL_W];
    end

    // A CTRL write that disables the timer suppresses a coincident count step.
    assign cnt_evt   = tick & (state_q == ST_RUN) & ~(ctrl_wr & ~ctrl_wdata.en);
    assign underflow = cnt_evt & (count_q == '0);

    timer_prescaler u_prescaler (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (ctrl_q.en),
        .i_clear (hi_wr),
        .i_term  (psel_to_div(ctrl_q.psel)),
        .o_tick  (tick)
    );

    // Counting first, bus writes last: a write to the same register overrides the count path.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phi2_q    <= 1'b0;
            latch_q   <= '0;
            count_q   <= '0;
            hi_snap_q <= '0;
            ctrl_q    <= '0;
            flag_q    <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            phi2_q <= i_phi2;

            if (cnt_evt) begin
                if (count_q != '0) begin
                    count_q <= count_q - COUNT_W'(1);
                end else if (ctrl_q.cont) begin
                    count_q <= latch_q;
                end else begin
                    ctrl_q.en <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            end

            if (wr && (i_addr == REG_STATUS) && i_data[STATUS_FLAG_BIT]) begin
                flag_q <= 1'b0;
            end
            if (underflow) begin
                flag_q <= 1'b1;
            end

            if (rd && (i_addr == REG_LATCH_LO)) begin
                hi_snap_q <= count_q[COUNT_W-1 -: DATA_W];
            end

            if (wr) begin
                case (i_addr)
                    REG_LATCH_LO: latch_q[DATA_W-1:0] <= i_data;
                    REG_LATCH_HI: begin
                        latch_q[COUNT_W-1 -: DATA_W] <= i_data;
                        count_q <= {i_data, latch_q[DATA_W-1:0]};
                    end
                    REG_CTRL: begin
                        ctrl_q  <= ctrl_wdata;
                        state_q <= ctrl_wdata.en ? ST_RUN : ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_irq_n = ~(flag_q & ctrl_q.ie);

    always_comb begin
        o_data = '0;
        if (i_cs && i_rw) begin
            case (i_addr)
                REG_LATCH_LO: o_data = count_q[DATA_W-1:0];
                REG_LATCH_HI: o_data = hi_snap_q;
                REG_CTRL:     o_data = DATA_W'(ctrl_q);
                default:      o_data = DATA_W'(flag_q);
            endcase
        end
    end

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: timestamp-based reference model compared every clock, directed
// scenarios with hand-computed expectations, then randomized register traffic.
module tb_interval_timer;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_phi2;
    logic       i_cs;
    logic [1:0] i_addr;
    logic       i_rw;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic       o_irq_n;

    interval_timer dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_phi2  (i_phi2),
        .i_cs    (i_cs),
        .i_addr  (i_addr),
        .i_rw    (i_rw),
        .i_data  (i_data),
        .o_data  (o_data),
        .o_irq_n (o_irq_n)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: ticks occur at fixed multiples of the divide ratio after the last phase origin.
    int          cyc     = 0;
    int          m_phase = 0;
    logic [15:0] m_latch = '0;
    logic [15:0] m_count = '0;
    logic [7:0]  m_snap  = '0;
    logic [1:0]  m_psel  = '0;
    logic        m_ie    = 1'b0;
    logic        m_cont  = 1'b0;
    logic        m_en    = 1'b0;
    logic        m_flag  = 1'b0;
    logic        m_phi2  = 1'b0;

    logic m_acc, m_wr, m_ctrl_wr, m_tick, m_step, m_uf, m_old_en;

    int          wr_cyc;
    logic        wr_irq_n;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic int div_of(input logic [1:0] p);
        case (p)
            2'd0:    return 1;
            2'd1:    return 8;
            2'd2:    return 64;
            default: return 256;
        endcase
    endfunction

    function automatic logic [7:0] exp_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_count[7:0];
            2'd1:    return m_snap;
            2'd2:    return {3'b000, m_psel, m_ie, m_cont, m_en};
            default: return {7'b0, m_flag};
        endcase
    endfunction

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_latch = '0; m_count = '0; m_snap = '0; m_psel = '0;
            m_ie = 1'b0; m_cont = 1'b0; m_en = 1'b0; m_flag = 1'b0; m_phi2 = 1'b0;
        end else begin
            cyc++;
            m_acc     = i_cs && i_phi2 && !m_phi2;
            m_phi2    = i_phi2;
            m_wr      = m_acc && !i_rw;
            m_ctrl_wr = m_wr && (i_addr == 2'd2);
            m_old_en  = m_en;
            m_tick    = m_en && (((cyc - m_phase) % div_of(m_psel)) == 0);
            m_step    = m_tick && !(m_ctrl_wr && !i_data[0]);
            m_uf      = m_step && (m_count == 16'd0);
            if (m_acc && i_rw && i_addr == 2'd0) m_snap = m_count[15:8];
            if (m_step) begin
                if (m_count != 16'd0) m_count = m_count - 16'd1;
                else if (m_cont)      m_count = m_latch;
                else                  m_en = 1'b0;
            end
            if (m_wr && i_addr == 2'd3 && i_data[0]) m_flag = 1'b0;
            if (m_uf) m_flag = 1'b1;
            if (m_wr) begin
                case (i_addr)
                    2'd0: m_latch[7:0] = i_data;
                    2'd1: begin
                        m_latch[15:8] = i_data;
                        m_count = {i_data, m_latch[7:0]};
                        m_phase = cyc;
                    end
                    2'd2: begin
                        m_psel = i_data[4:3]; m_ie = i_data[2]; m_cont = i_data[1]; m_en = i_data[0];
                        if (i_data[0] && !m_old_en) m_phase = cyc;
                    end
                    default: ;
                endcase
            end
            #1;
            check("irq_n", 32'(o_irq_n), 32'(!(m_flag && m_ie)));
            if (i_cs && i_rw) check("rdata", 32'(o_data), 32'(exp_read(i_addr)));
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge i_clk);
        i_cs = 1'b1; i_rw = 1'b0; i_addr = a; i_data = d; i_phi2 = 1'b1;
        @(posedge i_clk);
        #1;
        wr_cyc   = cyc;
        wr_irq_n = o_irq_n;
        @(negedge i_clk);
        i_phi2 = 1'b0; i_cs = 1'b0; i_rw = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge i_clk);
        i_cs = 1'b1; i_rw = 1'b1; i_addr = a; i_phi2 = 1'b1;
        #1 d = o_data;
        @(negedge i_clk);
        i_phi2 = 1'b0; i_cs = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wait_irq(input int max, output int at);
        at = -1;
        for (int k = 0; k < max; k++) begin
            @(posedge i_clk);
            #1;
            if (o_irq_n === 1'b0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("irq_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, lo, hi;
        int         c0, t, prev;

        i_reset = 1'b1; i_phi2 = 1'b0; i_cs = 1'b0; i_rw = 1'b1; i_addr = '0; i_data = '0;
        #12;
        check("reset_irq_n", 32'(o_irq_n), 32'd1);
        check("reset_odata_idle", 32'(o_data), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // One-shot, latch 5, /1, ie: IRQ exactly 6 clocks after enable
        bus_wr(2'd0, 8'h05);
        bus_wr(2'd1, 8'h00);
        bus_wr(2'd2, 8'h05);
        c0 = wr_cyc;
        wait_irq(20, t);
        check("oneshot_delay", 32'(t - c0), 32'd6);
        bus_rd(2'd0, lo);
        bus_rd(2'd1, hi);
        check("oneshot_count", 32'({hi, lo}), 32'h0000);
        bus_rd(2'd2, d);
        check("oneshot_en_cleared", 32'(d), 32'h04);
        bus_wr(2'd3, 8'h01);
        check("oneshot_clear_irq", 32'(wr_irq_n), 32'd1);

        // Continuous, latch 3, /8: period 32
        bus_wr(2'd0, 8'h03);
        bus_wr(2'd1, 8'h00);
        bus_wr(2'd2, 8'h0F);
        prev = wr_cyc;
        for (int i = 0; i < 4; i++) begin
            wait_irq(64, t);
            check("cont_period", 32'(t - prev), 32'd32);
            prev = t;
            bus_wr(2'd3, 8'h01);
        end
        bus_wr(2'd2, 8'h00);

        // Atomic read across the 0x0100 boundary
        bus_wr(2'd0, 8'h80);
        bus_wr(2'd1, 8'h01);
        bus_wr(2'd2, 8'h01);
        c0 = wr_cyc;
        wait_cyc(c0 + 129);
        bus_rd(2'd0, lo);
        bus_rd(2'd1, hi);
        check("atomic_read", 32'({hi, lo}), 32'h00FF);
        bus_wr(2'd2, 8'h00);

        // STATUS clear coinciding with the second underflow: set wins
        bus_wr(2'd0, 8'h05);
        bus_wr(2'd1, 8'h00);
        bus_wr(2'd2, 8'h07);
        c0 = wr_cyc;
        wait_cyc(c0 + 11);
        bus_wr(2'd3, 8'h01);
        check("clr_vs_uf_irq", 32'(wr_irq_n), 32'd0);
        bus_wr(2'd2, 8'h00);
        bus_rd(2'd3, d);
        check("clr_vs_uf_flag", 32'(d), 32'h01);
        bus_wr(2'd3, 8'h01);

        // LATCH_HI write coinciding with a reload underflow: write wins
        bus_wr(2'd0, 8'h34);
        bus_wr(2'd1, 8'h00);
        bus_wr(2'd2, 8'h13);
        c0 = wr_cyc;
        wait_cyc(c0 + 53 * 64 - 1);
        bus_wr(2'd1, 8'h12);
        bus_rd(2'd0, lo);
        bus_rd(2'd1, hi);
        check("hi_vs_reload", 32'({hi, lo}), 32'h1234);
        bus_rd(2'd3, d);
        check("hi_vs_reload_flag", 32'(d), 32'h01);
        bus_wr(2'd2, 8'h00);
        bus_wr(2'd3, 8'h01);

        // IRQ masking
        bus_wr(2'd0, 8'h02);
        bus_wr(2'd1, 8'h00);
        bus_wr(2'd2, 8'h01);
        c0 = wr_cyc;
        wait_cyc(c0 + 5);
        bus_rd(2'd3, d);
        check("mask_flag", 32'(d), 32'h01);
        check("mask_irq_n", 32'(o_irq_n), 32'd1);
        bus_wr(2'd2, 8'h04);
        check("unmask_irq_n", 32'(wr_irq_n), 32'd0);
        bus_wr(2'd3, 8'h01);

        // Asynchronous reset mid-count with IRQ pending
        bus_wr(2'd0, 8'h03);
        bus_wr(2'd1, 8'h00);
        bus_wr(2'd2, 8'h07);
        wait_irq(10, t);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        #2 i_reset = 1'b1;
        #1 check("rst_irq_n", 32'(o_irq_n), 32'd1);
        for (int a = 0; a < 4; a++) begin
            i_cs = 1'b1; i_rw = 1'b1; i_addr = 2'(a);
            #1 check("rst_reg_zero", 32'(o_data), 32'd0);
        end
        i_cs = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b0;
        bus_wr(2'd0, 8'h05);
        bus_wr(2'd1, 8'h00);
        repeat (20) @(posedge i_clk);
        bus_rd(2'd0, lo);
        check("rst_no_tick", 32'(lo), 32'h05);
        bus_rd(2'd3, d);
        check("rst_no_flag", 32'(d), 32'h00);

        // Randomized register traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int         op;
            logic [7:0] v;
            op = int'($urandom_range(0, 9));
            case (op)
                0: bus_wr(2'd0, 8'($urandom));
                1: bus_wr(2'd1, ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00);
                2, 3: begin
                    v = 8'($urandom);
                    v[0] = ($urandom_range(0, 3) != 0);
                    v[4:3] = ($urandom_range(0, 5) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
                    if (v[0] && m_en) v[4:3] = m_psel;
                    bus_wr(2'd2, v);
                end
                4: bus_wr(2'd3, 8'($urandom_range(0, 1)));
                5, 6: bus_rd(2'($urandom_range(0, 3)), d);
                default: repeat ($urandom_range(1, 20)) @(negedge i_clk);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
